// File: rtl/sc_rr_crossbar_master_port.sv
`default_nettype none
// ============================================================================
// Module   : sc_rr_crossbar_master_port
// Purpose  : Per-master request FIFO in front of the round-robin crossbar.
//            It presents the head entry to the arbiter, retires the head on the
//            granted slave's acknowledge, and returns a registered response.
//            It also counts the stall cycles of the current head.
// Revision : 1.0 - initial release
// ============================================================================
module sc_rr_crossbar_master_port #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_resetb,
  input  logic          i_cpu_valid,
  input  logic [31:0]   i_cpu_addr,
  input  logic [31:0]   i_cpu_wdata,
  input  logic          i_cpu_we,
  output logic          o_cpu_ready,
  output logic          o_ms_req,
  output logic [31:0]   o_ms_addr,
  output logic [31:0]   o_ms_wdata,
  output logic          o_ms_we,
  input  logic          i_s0_en,
  input  logic          i_s1_en,
  input  logic          i_sl0_ack,
  input  logic          i_sl1_ack,
  input  logic [31:0]   i_sl0_rdata,
  input  logic [31:0]   i_sl1_rdata,
  input  logic          i_wait,
  output logic          o_cpu_rvalid,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_rslave,
  output logic [LW-1:0] o_level,
  output logic [15:0]   o_stall_cnt
);

  localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

  logic [64:0]   r_mem [DEPTH];
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic          r_rslave;
  logic [15:0]   r_stall_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_sel0;
  logic          w_sel1;
  logic          w_complete;
  logic          w_pop;
  logic [64:0]   w_head;

  assign w_full  = (r_wr_ptr[LW-1] != r_rd_ptr[LW-1]) &&
                   (r_wr_ptr[LW-2:0] == r_rd_ptr[LW-2:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_cpu_valid & ~w_full;

  // An acknowledge only counts when it comes from the slave we are granted to.
  assign w_sel0     = i_s0_en & i_sl0_ack;
  assign w_sel1     = i_s1_en & i_sl1_ack;
  assign w_complete = w_sel0 | w_sel1;
  assign w_pop      = w_complete & ~w_empty;

  assign w_head = r_mem[r_rd_ptr[LW-2:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[LW-2:0]] <= {i_cpu_we, i_cpu_wdata, i_cpu_addr};
    end
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Both grants acknowledging together is a protocol violation; slave 0 wins.
  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rslave <= 1'b0;
    end else begin
      r_rvalid <= w_pop;
      if (w_pop) begin
        r_rslave <= ~w_sel0;
        if (w_head[64])  r_rdata <= '0;
        else if (w_sel0) r_rdata <= i_sl0_rdata;
        else             r_rdata <= i_sl1_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_stall_cnt <= '0;
    end else if (w_complete) begin
      r_stall_cnt <= '0;
    end else if (i_wait && (r_stall_cnt != c_STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_cpu_ready  = ~w_full;
  assign o_ms_req     = ~w_empty;
  assign o_ms_addr    = w_head[31:0];
  assign o_ms_wdata   = w_head[63:32];
  assign o_ms_we      = w_head[64];
  assign o_cpu_rvalid = r_rvalid;
  assign o_cpu_rdata  = r_rdata;
  assign o_cpu_rslave = r_rslave;
  assign o_level      = r_wr_ptr - r_rd_ptr;
  assign o_stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sc_rr_crossbar_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_rr_crossbar_master_port
// Purpose  : Self-checking bench: directed vector table, hand sequences for
//            stall saturation and async reset, and randomized reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_rr_crossbar_master_port;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          resetb;
  logic          cpu_valid, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_ready, ms_req, ms_we;
  logic [31:0]   ms_addr, ms_wdata;
  logic          s0_en, s1_en, sl0_ack, sl1_ack, wt;
  logic [31:0]   sl0_rdata, sl1_rdata;
  logic          cpu_rvalid, cpu_rslave;
  logic [31:0]   cpu_rdata;
  logic [LW-1:0] level;
  logic [15:0]   stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sc_rr_crossbar_master_port #(.DEPTH(DEPTH), .LW(LW)) dut (
    .i_clk(clk), .i_resetb(resetb),
    .i_cpu_valid(cpu_valid), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_cpu_we(cpu_we), .o_cpu_ready(cpu_ready),
    .o_ms_req(ms_req), .o_ms_addr(ms_addr), .o_ms_wdata(ms_wdata), .o_ms_we(ms_we),
    .i_s0_en(s0_en), .i_s1_en(s1_en), .i_sl0_ack(sl0_ack), .i_sl1_ack(sl1_ack),
    .i_sl0_rdata(sl0_rdata), .i_sl1_rdata(sl1_rdata), .i_wait(wt),
    .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata), .o_cpu_rslave(cpu_rslave),
    .o_level(level), .o_stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0;
    s0_en = 0; s1_en = 0; sl0_ack = 0; sl1_ack = 0;
    sl0_rdata = 0; sl1_rdata = 0; wt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;  logic [31:0] a;  logic we; logic [31:0] wd;
    logic        e0; logic e1; logic k0; logic k1;
    logic [31:0] d0; logic [31:0] d1; logic wt;
    logic        rdy; logic req; logic [31:0] ea; logic [LW-1:0] lvl;
    logic        rv;  logic [31:0] rd; logic rs; logic [15:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
      logic v, logic [31:0] a, logic we, logic [31:0] wd,
      logic e0, logic e1, logic k0, logic k1, logic [31:0] d0, logic [31:0] d1, logic w,
      logic rdy, logic req, logic [31:0] ea, logic [LW-1:0] lvl,
      logic rv, logic [31:0] rd, logic rs, logic [15:0] st);
    vec_t t;
    t.v = v; t.a = a; t.we = we; t.wd = wd; t.e0 = e0; t.e1 = e1; t.k0 = k0; t.k1 = k1;
    t.d0 = d0; t.d1 = d1; t.wt = w; t.rdy = rdy; t.req = req; t.ea = ea; t.lvl = lvl;
    t.rv = rv; t.rd = rd; t.rs = rs; t.st = st;
    tbl.push_back(t);
  endfunction

  // ---------------- reference model ----------------
  logic [64:0] q[$];
  logic        m_rvalid, m_rslave;
  logic [31:0] m_rdata;
  int          m_stall;

  function automatic void model_reset();
    q.delete(); m_rvalid = 0; m_rdata = 0; m_rslave = 0; m_stall = 0;
  endfunction

  function automatic void model_step();
    bit sel0, sel1, complete, push;
    sel0 = s0_en && sl0_ack;
    sel1 = s1_en && sl1_ack;
    complete = sel0 || sel1;
    push = cpu_valid && (q.size() < DEPTH);
    m_rvalid = 0;
    if (complete && q.size() > 0) begin
      logic [64:0] h;
      h = q.pop_front();
      m_rvalid = 1;
      m_rslave = sel0 ? 1'b0 : 1'b1;
      m_rdata  = h[64] ? 32'd0 : (sel0 ? sl0_rdata : sl1_rdata);
    end
    if (complete) m_stall = 0;
    else if (wt && m_stall < 65535) m_stall++;
    if (push) q.push_back({cpu_we, cpu_wdata, cpu_addr});
  endfunction

  task automatic check_model();
    chk("rnd_ready", {31'd0, cpu_ready}, {31'd0, q.size() < DEPTH});
    chk("rnd_req",   {31'd0, ms_req},    {31'd0, q.size() > 0});
    chk("rnd_level", {29'd0, level},     q.size());
    if (q.size() > 0) begin
      chk("rnd_addr",  ms_addr,  q[0][31:0]);
      chk("rnd_wdata", ms_wdata, q[0][63:32]);
      chk("rnd_we",    {31'd0, ms_we}, {31'd0, q[0][64]});
    end
    chk("rnd_rvalid", {31'd0, cpu_rvalid}, {31'd0, m_rvalid});
    chk("rnd_rdata",  cpu_rdata, m_rdata);
    chk("rnd_rslave", {31'd0, cpu_rslave}, {31'd0, m_rslave});
    chk("rnd_stall",  {16'd0, stall_cnt}, m_stall);
  endtask

  initial begin
    // read flow through slave 0
    add(1,32'h10,0,0,       0,0,0,0,0,0,0,  1,1,32'h10,1, 0,0,0,0);
    add(0,0,0,0,            1,0,0,0,0,0,0,  1,1,32'h10,1, 0,0,0,0);
    add(0,0,0,0,            1,0,1,0,32'hDEADBEEF,0,0, 1,0,0,0, 1,32'hDEADBEEF,0,0);
    add(0,0,0,0,            0,0,0,0,0,0,0,  1,0,0,0, 0,32'hDEADBEEF,0,0);
    // fill to full, reject fifth, then full pop with offered push
    add(1,32'h100,0,0,      0,0,0,0,0,0,0,  1,1,32'h100,1, 0,32'hDEADBEEF,0,0);
    add(1,32'h104,0,0,      0,0,0,0,0,0,0,  1,1,32'h100,2, 0,32'hDEADBEEF,0,0);
    add(1,32'h108,0,0,      0,0,0,0,0,0,0,  1,1,32'h100,3, 0,32'hDEADBEEF,0,0);
    add(1,32'h10C,0,0,      0,0,0,0,0,0,0,  0,1,32'h100,4, 0,32'hDEADBEEF,0,0);
    add(1,32'h110,0,0,      0,0,0,0,0,0,1,  0,1,32'h100,4, 0,32'hDEADBEEF,0,1);
    add(1,32'h110,0,0,      1,0,1,0,32'h55,0,1, 1,1,32'h104,3, 1,32'h55,0,0);
    add(1,32'h110,0,0,      1,0,1,0,32'h66,0,0, 1,1,32'h108,3, 1,32'h66,0,0);
    add(0,0,0,0,            1,0,1,0,32'h77,0,0, 1,1,32'h10C,2, 1,32'h77,0,0);
    add(0,0,0,0,            1,0,1,0,32'h88,0,0, 1,1,32'h110,1, 1,32'h88,0,0);
    add(0,0,0,0,            1,0,1,0,32'h99,0,0, 1,0,0,0, 1,32'h99,0,0);
    // write to slave 1, mismatched ack ignored
    add(1,32'h80000004,1,32'h1234, 0,0,0,0,0,0,0, 1,1,32'h80000004,1, 0,32'h99,0,0);
    add(0,0,0,0,            0,1,1,0,32'hBAD,0,1, 1,1,32'h80000004,1, 0,32'h99,0,1);
    add(0,0,0,0,            0,1,0,1,0,32'hCAFE,0, 1,0,0,0, 1,0,1,0);
    add(0,0,0,0,            0,0,0,0,0,0,0,  1,0,0,0, 0,0,1,0);
    // both grants acknowledge: slave 0 wins
    add(1,32'h80000000,0,0, 0,0,0,0,0,0,0,  1,1,32'h80000000,1, 0,0,1,0);
    add(0,0,0,0,            1,1,1,1,32'hA0,32'hB1,0, 1,0,0,0, 1,32'hA0,0,0);

    resetb = 1'b1;
    idle_inputs();
    #2 resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  {31'd0, cpu_ready}, 32'd1);
    chk("rst_req",    {31'd0, ms_req},    32'd0);
    chk("rst_level",  {29'd0, level},     32'd0);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_rdata",  cpu_rdata, 32'd0);
    chk("rst_rslave", {31'd0, cpu_rslave}, 32'd0);
    chk("rst_stall",  {16'd0, stall_cnt}, 32'd0);
    resetb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", {31'd0, cpu_ready}, 32'd1);
    chk("idle_req",   {31'd0, ms_req},    32'd0);

    foreach (tbl[i]) begin
      cpu_valid = tbl[i].v; cpu_addr = tbl[i].a; cpu_we = tbl[i].we; cpu_wdata = tbl[i].wd;
      s0_en = tbl[i].e0; s1_en = tbl[i].e1; sl0_ack = tbl[i].k0; sl1_ack = tbl[i].k1;
      sl0_rdata = tbl[i].d0; sl1_rdata = tbl[i].d1; wt = tbl[i].wt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, cpu_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d_req", i),   {31'd0, ms_req},    {31'd0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), ms_addr, tbl[i].ea);
      chk($sformatf("v%0d_level", i), {29'd0, level}, {29'd0, tbl[i].lvl});
      chk($sformatf("v%0d_rvalid", i), {31'd0, cpu_rvalid}, {31'd0, tbl[i].rv});
      chk($sformatf("v%0d_rdata", i), cpu_rdata, tbl[i].rd);
      chk($sformatf("v%0d_rslave", i), {31'd0, cpu_rslave}, {31'd0, tbl[i].rs});
      chk($sformatf("v%0d_stall", i), {16'd0, stall_cnt}, {16'd0, tbl[i].st});
    end
    idle_inputs();

    // stall counter saturation, then clear on complete
    cpu_valid = 1; cpu_addr = 32'h20;
    @(posedge clk); #1;
    cpu_valid = 0; wt = 1;
    repeat (65600) @(posedge clk);
    #1;
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    s0_en = 1; sl0_ack = 1; sl0_rdata = 32'h5A5A;
    @(posedge clk); #1;
    idle_inputs();
    chk("stall_clear", {16'd0, stall_cnt}, 32'd0);
    chk("stall_rdata", cpu_rdata, 32'h5A5A);

    // asynchronous reset with three entries queued and a live grant
    for (int k = 0; k < 3; k++) begin
      cpu_valid = 1; cpu_addr = 32'h300 + k;
      @(posedge clk); #1;
    end
    cpu_valid = 0;
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    s0_en = 1; sl0_ack = 1; sl0_rdata = 32'h77777777;
    #2 resetb = 1'b0;
    #1;
    chk("arst_req",   {31'd0, ms_req}, 32'd0);
    chk("arst_level", {29'd0, level},  32'd0);
    chk("arst_ready", {31'd0, cpu_ready}, 32'd1);
    @(posedge clk); #1;
    resetb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("post_rst_level",  {29'd0, level}, 32'd0);
    end

    // randomized against the queue model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int g;
      check_model();
      cpu_valid = $urandom_range(0, 1);
      cpu_addr  = $urandom();
      cpu_wdata = $urandom();
      cpu_we    = $urandom_range(0, 1);
      g = $urandom_range(0, 4);
      s0_en = 0; s1_en = 0;
      if (g == 1 || g == 2) begin
        if (q.size() > 0 && q[0][31]) s1_en = 1; else s0_en = 1;
      end else if (g == 3) begin
        if (q.size() > 0 && q[0][31]) s0_en = 1; else s1_en = 1;
      end else if (g == 4 && $urandom_range(0, 7) == 0) begin
        s0_en = 1; s1_en = 1;
      end
      sl0_ack   = $urandom_range(0, 1);
      sl1_ack   = $urandom_range(0, 1);
      sl0_rdata = $urandom();
      sl1_rdata = $urandom();
      wt        = $urandom_range(0, 1);
      model_step();
      @(posedge clk); #1;
    end
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
